// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add multiplier: FSM, datapath and iteration counter.
// Signed operands handled as sign-magnitude, with optional early termination.
module seq_multiplier_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_hi_nx;
  logic [WIDTH-1:0]   acc_lo_nx;
  logic [WIDTH-1:0]   mplr_nx;
  logic [CW-1:0]      count_nx;
  logic               calc_last;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] p_raw;
  logic [2*WIDTH-1:0] p_algn;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_CALC;
      S_CALC: if (calc_last) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One shift-add step, operand magnitudes and result alignment
  always_comb begin
    a_abs = multiplicand;
    b_abs = multiplier;
    if (signed_mode && multiplicand[WIDTH-1]) a_abs = -multiplicand;
    if (signed_mode && multiplier[WIDTH-1])   b_abs = -multiplier;
    sum       = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_hi_nx = sum[WIDTH:1];
    acc_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};
    mplr_nx   = {acc_lo[0], mplr[WIDTH-1:1]};
    count_nx  = count - CW'(1);
    calc_last = (count_nx == '0) || (EARLY_EXIT && (mplr_nx == '0));
    p_raw     = {acc_hi, acc_lo};
    p_algn    = p_raw >> count;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplr    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_abs;
            mplr   <= b_abs;
            neg    <= signed_mode &
                      (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= CNT_INIT;
          end
        end
        S_CALC: begin
          acc_hi <= acc_hi_nx;
          acc_lo <= acc_lo_nx;
          mplr   <= mplr_nx;
          count  <= count_nx;
        end
        S_FIX: begin
          product <= neg ? -p_algn : p_algn;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_CALC) || (state == S_FIX);
  assign done  = (state == S_DONE);

endmodule
